// File: rtl/ifetch_unit_if.sv
// ---------------------------------------------------------------------------
// ifetch_unit_if
// Request/acknowledge bus between the instruction-fetch front end and a
// variable-latency instruction memory.
//
//   imem_req    fetch request, held high until imem_ack
//   imem_addr   fetch address, stable while imem_req is high
//   imem_rdata  instruction word, meaningful only while imem_ack is high
//   imem_ack    one-cycle response pulse for the outstanding request
//
// Modports:
//   master  - fetch unit side (drives req/addr)
//   slave   - memory side (drives rdata/ack)
// ---------------------------------------------------------------------------
interface ifetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );
endinterface

// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
// Instruction-fetch front end for the multi-cycle controller. Keeps a
// one-deep prefetch buffer filled from instruction memory, hands words to the
// current-instruction register on write_ir, and owns the architectural PC
// including redirects (ALU target, PC-relative branch, reset vector) that
// flush the prefetch path.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   write_ir     load I from the prefetch buffer (or from a same-cycle ack)
//   write_pc     update PC according to pc_s
//   pc_s         00 pc+4, 01 alu_f, 10 branch, 11 RESET_VEC
//   alu_f        ALU result, target for pc_s=01
//   imm24        branch word offset, target for pc_s=10
//   imem         instruction memory request/ack bus (master side)
//   I            current instruction register
//   IR_buf       prefetched next instruction
//   W_IR_valid   IR_buf holds a usable instruction
//   pc           address of the instruction in I
//   ir_underrun  sticky: write_ir arrived with nothing to deliver
// ---------------------------------------------------------------------------
module ifetch_unit #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                write_ir,
    input  logic                write_pc,
    input  logic [1:0]          pc_s,
    input  logic [31:0]         alu_f,
    input  logic [23:0]         imm24,
    ifetch_unit_if.master       imem,
    output logic [31:0]         I,
    output logic [31:0]         IR_buf,
    output logic                W_IR_valid,
    output logic [31:0]         pc,
    output logic                ir_underrun
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // nothing outstanding
        ST_REQ   = 2'd1,   // request outstanding, data wanted
        ST_FLUSH = 2'd2    // request outstanding, data stale after redirect
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] fetch_addr_reg;   // next address to fetch
    logic [31:0] buf_addr_reg;     // address of the word in ir_buf_reg
    logic [31:0] ir_reg;
    logic [31:0] ir_buf_reg;
    logic        valid_reg;
    logic        underrun_reg;
    logic        req_reg;
    logic [31:0] addr_reg;

    // -----------------------------------------------------------------------
    // Branch offset: sign-extended imm24 scaled to a byte offset.
    // -----------------------------------------------------------------------
    logic [31:0] branch_offset;

    assign branch_offset[1:0] = 2'b00;

    generate
        for (genvar gi = 0; gi < 24; gi++) begin : g_off_field
            assign branch_offset[gi + 2] = imm24[gi];
        end
        for (genvar gi = 26; gi < 32; gi++) begin : g_off_sign
            assign branch_offset[gi] = imm24[23];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Redirect decode and target selection
    // -----------------------------------------------------------------------
    logic        redirect;
    logic [31:0] target;

    assign redirect = write_pc && (pc_s != 2'b00);

    always_comb begin
        target = pc_reg + 32'd4;
        case (pc_s)
            2'b01:   target = alu_f;
            2'b10:   target = pc_reg + 32'd8 + branch_offset;
            2'b11:   target = RESET_VEC;
            default: target = pc_reg + 32'd4;
        endcase
    end

    // Buffer occupancy as seen after this cycle's write_ir, used by IDLE to
    // decide whether a new fetch is needed right away.
    logic valid_after_ir;
    assign valid_after_ir = valid_reg && !write_ir;

    // -----------------------------------------------------------------------
    // Fetch FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            pc_reg         <= RESET_VEC;
            fetch_addr_reg <= RESET_VEC;
            buf_addr_reg   <= RESET_VEC;
            ir_reg         <= NOP_INSTR;
            ir_buf_reg     <= 32'h0;
            valid_reg      <= 1'b0;
            underrun_reg   <= 1'b0;
            req_reg        <= 1'b0;
            addr_reg       <= 32'h0;
        end else if (redirect) begin
            // Redirect beats write_ir: I is left alone and no underrun is
            // flagged. Any in-flight word belongs to the old stream.
            pc_reg         <= target;
            fetch_addr_reg <= target;
            valid_reg      <= 1'b0;
            case (state_reg)
                ST_REQ, ST_FLUSH: begin
                    if (imem.imem_ack) begin
                        req_reg   <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        state_reg <= ST_FLUSH;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end else begin
            // Sequential advance; a write_ir in the same cycle overrides it
            // below because it names the actual address of the new word.
            if (write_pc) begin
                pc_reg <= pc_reg + 32'd4;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (write_ir) begin
                        if (valid_reg) begin
                            ir_reg    <= ir_buf_reg;
                            pc_reg    <= buf_addr_reg;
                            valid_reg <= 1'b0;
                        end else begin
                            underrun_reg <= 1'b1;
                        end
                    end
                    if (!valid_after_ir) begin
                        req_reg   <= 1'b1;
                        addr_reg  <= fetch_addr_reg;
                        state_reg <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    if (imem.imem_ack) begin
                        req_reg        <= 1'b0;
                        state_reg      <= ST_IDLE;
                        fetch_addr_reg <= addr_reg + 32'd4;
                        if (write_ir && !valid_reg) begin
                            // Bypass: the arriving word goes straight to I
                            // and the buffer stays empty.
                            ir_reg <= imem.imem_rdata;
                            pc_reg <= addr_reg;
                        end else begin
                            ir_buf_reg   <= imem.imem_rdata;
                            buf_addr_reg <= addr_reg;
                            valid_reg    <= 1'b1;
                            if (write_ir) begin
                                ir_reg <= ir_buf_reg;
                                pc_reg <= buf_addr_reg;
                            end
                        end
                    end else if (write_ir) begin
                        if (valid_reg) begin
                            ir_reg    <= ir_buf_reg;
                            pc_reg    <= buf_addr_reg;
                            valid_reg <= 1'b0;
                        end else begin
                            underrun_reg <= 1'b1;
                        end
                    end
                end

                ST_FLUSH: begin
                    // Stale response: drop the data, just close the request.
                    if (imem.imem_ack) begin
                        req_reg   <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                    if (write_ir) begin
                        if (valid_reg) begin
                            ir_reg    <= ir_buf_reg;
                            pc_reg    <= buf_addr_reg;
                            valid_reg <= 1'b0;
                        end else begin
                            underrun_reg <= 1'b1;
                        end
                    end
                end

                default: begin
                    req_reg   <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign imem.imem_req  = req_reg;
    assign imem.imem_addr = addr_reg;
    assign I              = ir_reg;
    assign IR_buf         = ir_buf_reg;
    assign W_IR_valid     = valid_reg;
    assign pc             = pc_reg;
    assign ir_underrun    = underrun_reg;

endmodule

// File: tb/tb_ifetch_unit.sv
// ---------------------------------------------------------------------------
// tb_ifetch_unit
// Self-checking bench for ifetch_unit. A behavioural memory answers requests
// after a configurable random latency; a transaction-level model tracks the
// address of the next instruction to be delivered and the next address that
// must be fetched, so each delivered (I, pc) pair is checked against the
// memory contents at the expected address.
// ---------------------------------------------------------------------------
module tb_ifetch_unit;
    localparam logic [31:0] NOP = 32'hE1A0_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        write_ir;
    logic        write_pc;
    logic [1:0]  pc_s;
    logic [31:0] alu_f;
    logic [23:0] imm24;
    logic [31:0] I;
    logic [31:0] IR_buf;
    logic        W_IR_valid;
    logic [31:0] pc;
    logic        ir_underrun;

    ifetch_unit_if bus();

    ifetch_unit #(
        .RESET_VEC (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .write_ir    (write_ir),
        .write_pc    (write_pc),
        .pc_s        (pc_s),
        .alu_f       (alu_f),
        .imm24       (imm24),
        .imem        (bus),
        .I           (I),
        .IR_buf      (IR_buf),
        .W_IR_valid  (W_IR_valid),
        .pc          (pc),
        .ir_underrun (ir_underrun)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Memory responder state
    bit          auto_mem = 1'b0;
    int          lat_min  = 1;
    int          lat_max  = 1;
    bit          busy     = 1'b0;
    int          cnt      = 0;
    logic [31:0] req_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0)
            return 32'hE3A0_1005;
        else if (a == 32'h8)
            return 32'hE081_2003;
        else
            return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    // One clock: advance to just after the edge, then let the memory decide
    // this cycle's response.
    task automatic step();
        @(posedge clk);
        #1;
        if (auto_mem) begin
            bus.imem_ack = 1'b0;
            if (busy) begin
                if (cnt == 0) begin
                    n_checks++;
                    if (bus.imem_req !== 1'b1 || bus.imem_addr !== req_addr) begin
                        n_fail++;
                        $display("FAIL addr_stable: req=%0b addr=%h required req=1 addr=%h",
                                 bus.imem_req, bus.imem_addr, req_addr);
                    end
                    bus.imem_ack   = 1'b1;
                    bus.imem_rdata = mem_word(req_addr);
                    busy           = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (bus.imem_req === 1'b1) begin
                busy     = 1'b1;
                req_addr = bus.imem_addr;
                cnt      = int'($urandom_range(lat_max, lat_min)) - 1;
            end
        end
    endtask

    task automatic do_reset();
        auto_mem       = 1'b0;
        busy           = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        write_ir       = 1'b0;
        write_pc       = 1'b0;
        pc_s           = 2'b00;
        rst            = 1'b1;
        step();
        step();
        rst      = 1'b0;
        auto_mem = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (W_IR_valid !== 1'b1 && k < 100) begin
            step();
            k++;
        end
        n_checks++;
        if (W_IR_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_wait_valid: W_IR_valid=%0b required 1 within 100 cycles", name, W_IR_valid);
        end
    endtask

    task automatic wait_ack(input string name);
        int k = 0;
        while (bus.imem_ack !== 1'b1 && k < 100) begin
            step();
            k++;
        end
        n_checks++;
        if (bus.imem_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_wait_ack: no ack within 100 cycles", name);
        end
    endtask

    task automatic pulse_ir();
        write_ir = 1'b1;
        step();
        write_ir = 1'b0;
    endtask

    task automatic redirect(input logic [1:0] sel, input logic [31:0] a, input logic [23:0] imm);
        write_pc = 1'b1;
        pc_s     = sel;
        alu_f    = a;
        imm24    = imm;
        step();
        write_pc = 1'b0;
        pc_s     = 2'b00;
    endtask

    // Consume one instruction and check it came from address exp.
    task automatic take_and_check(input string name, input logic [31:0] exp);
        wait_valid(name);
        pulse_ir();
        n_checks++;
        if (I !== mem_word(exp) || pc !== exp) begin
            n_fail++;
            $display("FAIL %s_take: I=%h pc=%h required I=%h pc=%h", name, I, pc, mem_word(exp), exp);
        end
        $display("take %s: pc=%h I=%h", name, pc, I);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        auto_mem = 1'b0;
        busy     = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0;
        write_ir = 1'b0;
        write_pc = 1'b0;
        pc_s = 2'b00;
        alu_f = 32'h0;
        imm24 = 24'h0;
        rst = 1'b1;
        step();
        step();
        step();
        n_checks++;
        if (I !== NOP || pc !== 32'h0 || IR_buf !== 32'h0 || W_IR_valid !== 1'b0 ||
            bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0 || ir_underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: I=%h pc=%h buf=%h v=%0b req=%0b addr=%h un=%0b required %h 0 0 0 0 0 0",
                     I, pc, IR_buf, W_IR_valid, bus.imem_req, bus.imem_addr, ir_underrun, NOP);
        end
        $display("reset: I=%h pc=%h req=%0b", I, pc, bus.imem_req);

        rst = 1'b0;
        auto_mem = 1'b1;
        lat_min = 1;
        lat_max = 1;
        step();
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL first_req: req=%0b addr=%h required 1 00000000", bus.imem_req, bus.imem_addr);
        end
        step();
        step();
        n_checks++;
        if (IR_buf !== 32'hE3A0_1005 || W_IR_valid !== 1'b1 || I !== NOP || bus.imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL first_fill: buf=%h v=%0b I=%h req=%0b required e3a01005 1 %h 0",
                     IR_buf, W_IR_valid, I, bus.imem_req, NOP);
        end
        step();
        step();
        n_checks++;
        if (bus.imem_req !== 1'b0 || I !== NOP) begin
            n_fail++;
            $display("FAIL full_hold: req=%0b I=%h required 0 %h", bus.imem_req, I, NOP);
        end
        pulse_ir();
        n_checks++;
        if (I !== 32'hE3A0_1005 || pc !== 32'h0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin
            n_fail++;
            $display("FAIL first_take: I=%h pc=%h req=%0b addr=%h required e3a01005 0 1 4",
                     I, pc, bus.imem_req, bus.imem_addr);
        end
        $display("first take: I=%h pc=%h next addr=%h", I, pc, bus.imem_addr);
    endtask

    task automatic test_sequential();
        do_reset();
        lat_min = 3;
        lat_max = 3;
        for (int k = 0; k < 4; k++) begin
            take_and_check("seq", 32'(k * 4));
        end
    endtask

    task automatic test_bypass();
        do_reset();
        lat_min = 2;
        lat_max = 2;
        take_and_check("byp_pre", 32'h0);
        take_and_check("byp_pre", 32'h4);
        wait_ack("byp");
        n_checks++;
        if (bus.imem_addr !== 32'h8 || W_IR_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL byp_setup: addr=%h v=%0b required 8 0", bus.imem_addr, W_IR_valid);
        end
        pulse_ir();
        n_checks++;
        if (I !== 32'hE081_2003 || pc !== 32'h8 || W_IR_valid !== 1'b0 || ir_underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass: I=%h pc=%h v=%0b un=%0b required e0812003 8 0 0",
                     I, pc, W_IR_valid, ir_underrun);
        end
        $display("bypass: I=%h pc=%h", I, pc);
        step();
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC) begin
            n_fail++;
            $display("FAIL byp_next: req=%0b addr=%h required 1 c", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_redirect_flush();
        do_reset();
        lat_min = 4;
        lat_max = 4;
        for (int k = 0; k < 4; k++) begin
            take_and_check("fl_pre", 32'(k * 4));
        end
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL fl_out: req=%0b addr=%h required 1 10", bus.imem_req, bus.imem_addr);
        end
        redirect(2'b01, 32'h200, 24'h0);
        n_checks++;
        if (pc !== 32'h200 || W_IR_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL fl_hold: pc=%h v=%0b req=%0b addr=%h required 200 0 1 10",
                     pc, W_IR_valid, bus.imem_req, bus.imem_addr);
        end
        wait_ack("fl");
        step();
        n_checks++;
        if (W_IR_valid !== 1'b0 || bus.imem_req !== 1'b0 || IR_buf !== mem_word(32'hC)) begin
            n_fail++;
            $display("FAIL fl_discard: v=%0b req=%0b buf=%h required 0 0 %h",
                     W_IR_valid, bus.imem_req, IR_buf, mem_word(32'hC));
        end
        step();
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL fl_target: req=%0b addr=%h required 1 200", bus.imem_req, bus.imem_addr);
        end
        take_and_check("fl_post", 32'h200);
        take_and_check("fl_post", 32'h204);
    endtask

    task automatic test_branch();
        do_reset();
        lat_min = 2;
        lat_max = 2;
        redirect(2'b01, 32'h100, 24'h0);
        n_checks++;
        if (pc !== 32'h100) begin
            n_fail++;
            $display("FAIL br_setup: pc=%h required 100", pc);
        end
        wait_valid("br1");
        redirect(2'b10, 32'h0, 24'hFFFFFE);
        n_checks++;
        if (pc !== 32'h100 || W_IR_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL br_back: pc=%h v=%0b required 100 0", pc, W_IR_valid);
        end
        $display("branch -2: pc=%h", pc);
        wait_valid("br2");
        redirect(2'b10, 32'h0, 24'h000003);
        n_checks++;
        if (pc !== 32'h114 || W_IR_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL br_fwd: pc=%h v=%0b required 114 0", pc, W_IR_valid);
        end
        $display("branch +3: pc=%h", pc);
        take_and_check("br_post", 32'h114);
        redirect(2'b11, 32'h0, 24'h0);
        n_checks++;
        if (pc !== 32'h0) begin
            n_fail++;
            $display("FAIL br_rstvec: pc=%h required 0", pc);
        end
        take_and_check("rv_post", 32'h0);
    endtask

    task automatic test_underrun_and_reset();
        do_reset();
        lat_min = 4;
        lat_max = 4;
        step();
        pulse_ir();
        n_checks++;
        if (ir_underrun !== 1'b1 || I !== NOP || pc !== 32'h0) begin
            n_fail++;
            $display("FAIL underrun_set: un=%0b I=%h pc=%h required 1 %h 0", ir_underrun, I, pc, NOP);
        end
        take_and_check("un_post", 32'h0);
        n_checks++;
        if (ir_underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL underrun_sticky: un=%0b required 1", ir_underrun);
        end
        n_checks++;
        if (bus.imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: req=%0b required 1", bus.imem_req);
        end
        // Reset mid-request, then a late ack lands while the unit is idle.
        auto_mem = 1'b0;
        busy = 1'b0;
        bus.imem_ack = 1'b0;
        rst = 1'b1;
        step();
        n_checks++;
        if (bus.imem_req !== 1'b0 || ir_underrun !== 1'b0 || I !== NOP || pc !== 32'h0 || W_IR_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: req=%0b un=%0b I=%h pc=%h v=%0b required 0 0 %h 0 0",
                     bus.imem_req, ir_underrun, I, pc, W_IR_valid, NOP);
        end
        rst = 1'b0;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        step();
        bus.imem_ack = 1'b0;
        n_checks++;
        if (W_IR_valid !== 1'b0 || IR_buf !== 32'h0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL late_ack: v=%0b buf=%h req=%0b addr=%h required 0 0 1 0",
                     W_IR_valid, IR_buf, bus.imem_req, bus.imem_addr);
        end
        $display("late ack ignored: v=%0b req=%0b", W_IR_valid, bus.imem_req);
        auto_mem = 1'b1;
        take_and_check("rst_post", 32'h0);
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] exp_next;
        logic [31:0] exp_fetch;
        logic [31:0] tgt;
        logic [31:0] addr_before;
        bit          stale;
        bit          ack_now;
        bit          accept;
        bit          redir;
        bit          wir;
        bit          req_before;
        int          off;
        int          n_take;
        int          n_redir;

        do_reset();
        lat_min   = 1;
        lat_max   = 5;
        exp_pc    = 32'h0;
        exp_next  = 32'h0;
        exp_fetch = 32'h0;
        stale     = 1'b0;
        n_take    = 0;
        n_redir   = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            ack_now     = (bus.imem_ack === 1'b1) && (bus.imem_req === 1'b1);
            accept      = ack_now && !stale;
            req_before  = (bus.imem_req === 1'b1);
            addr_before = bus.imem_addr;
            redir       = ($urandom_range(0, 24) == 0);
            wir         = ($urandom_range(0, 2) == 0) && ((W_IR_valid === 1'b1) || accept || redir);
            tgt         = 32'h0;
            if (redir) begin
                pc_s = 2'($urandom_range(1, 3));
                alu_f = 32'($urandom_range(0, 4095)) << 2;
                off = int'($urandom_range(0, 64)) - 32;
                imm24 = off[23:0];
                case (pc_s)
                    2'b01:   tgt = alu_f;
                    2'b10:   tgt = exp_pc + 32'd8 + 32'(off * 4);
                    default: tgt = 32'h0;
                endcase
                write_pc = 1'b1;
            end
            write_ir = wir;
            step();
            write_ir = 1'b0;
            write_pc = 1'b0;
            if (redir) begin
                n_redir++;
                exp_pc    = tgt;
                exp_next  = tgt;
                exp_fetch = tgt;
                stale     = req_before && !ack_now;
                n_checks++;
                if (pc !== tgt || W_IR_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd_redirect: pc=%h v=%0b required %h 0", pc, W_IR_valid, tgt);
                end
            end else begin
                if (accept) begin
                    n_checks++;
                    if (addr_before !== exp_fetch) begin
                        n_fail++;
                        $display("FAIL rnd_fetch_addr: addr=%h required %h", addr_before, exp_fetch);
                    end
                    exp_fetch = exp_fetch + 32'd4;
                end
                if (ack_now && stale)
                    stale = 1'b0;
                if (wir) begin
                    n_take++;
                    n_checks++;
                    if (I !== mem_word(exp_next) || pc !== exp_next) begin
                        n_fail++;
                        $display("FAIL rnd_take: I=%h pc=%h required I=%h pc=%h",
                                 I, pc, mem_word(exp_next), exp_next);
                    end
                    exp_pc   = exp_next;
                    exp_next = exp_next + 32'd4;
                end
            end
        end
        n_checks++;
        if (ir_underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_underrun: un=%0b required 0", ir_underrun);
        end
        $display("random: %0d takes, %0d redirects", n_take, n_redir);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_bypass();
        test_redirect_flush();
        test_branch();
        test_underrun_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
